led_pattern_engine: RTL and testbench

//  Static-region LED pattern generator; successor to the fixed 4-LED prescaler/shift/count top level.

---
 rtl/led_pattern_pkg.sv | 20 ++
 rtl/led_pattern_engine_btn_debounce.sv | 47 ++++
 rtl/led_pattern_engine.sv | 107 ++++++++++
 tb/tb_led_pattern_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and channel reload values for the LED pattern engine.
package led_pattern_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_CNT_UP = 2'd2;
    localparam logic [1:0] MODE_CNT_DN = 2'd3;

    localparam int LED_MAX = 32;

    // Pattern a channel restarts from when the mode changes; callers truncate to their width.
    function automatic logic [LED_MAX-1:0] reload_value(input logic [1:0] mode);
        case (mode)
            MODE_CNT_UP: return '0;
            MODE_CNT_DN: return '1;
            default:     return LED_MAX'(1);
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_engine_btn_debounce.sv
// Two-flop synchroniser plus stability counter for the raw mode button.
module btn_debounce #(
    parameter int DB_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_rise
);

    logic sync1;
    logic sync2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Any sample agreeing with the stable state restarts the count; 2**DB_W disagreements flip it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            btn_stable <= 1'b0;
            btn_rise   <= 1'b0;
        end else if (sync2 != btn_stable) begin
            if (cnt == '1) begin
                cnt        <= '0;
                btn_stable <= sync2;
                btn_rise   <= sync2;
            end else begin
                cnt      <= cnt + DB_W'(1);
                btn_rise <= 1'b0;
            end
        end else begin
            cnt      <= '0;
            btn_rise <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// Shared-prescaler LED pattern generator with NUM_CH channels and a button-stepped global mode.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int LED_W   = 4,
    parameter int NUM_CH  = 2,
    parameter int PRESC_W = 23,
    parameter int DB_W    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode_btn,
    output logic [NUM_CH*LED_W-1:0] led_out,
    output logic [1:0]              mode_out,
    output logic                    tick_out
);

    localparam int DIV_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PRESC_W-1:0] presc;
    logic               wrap;
    logic               btn_stable;
    logic               btn_rise;
    logic               mode_adv;
    logic               reload;
    logic [LED_W-1:0]   reload_pat;

    assign wrap = en && (presc == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= wrap;
            if (en) begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    btn_debounce #(
        .DB_W(DB_W)
    ) u_btn_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (mode_btn),
        .btn_stable(btn_stable),
        .btn_rise  (btn_rise)
    );

    assign mode_adv = btn_rise && btn_stable;

    // Channels reload one edge after the mode register moves, so they see the new mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_out <= MODE_ROT_L;
            reload   <= 1'b0;
        end else begin
            reload <= mode_adv;
            if (mode_adv) begin
                mode_out <= mode_out + 2'd1;
            end
        end
    end

    assign reload_pat = LED_W'(reload_value(mode_out));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [LED_W-1:0] pattern;
        logic [LED_W-1:0] step_val;
        logic [DIV_W-1:0] div;

        always_comb begin
            step_val = pattern;
            case (mode_out)
                MODE_ROT_L:  step_val = {pattern[LED_W-2:0], pattern[LED_W-1]};
                MODE_ROT_R:  step_val = {pattern[0], pattern[LED_W-1:1]};
                MODE_CNT_UP: step_val = pattern + LED_W'(1);
                MODE_CNT_DN: step_val = pattern - LED_W'(1);
                default:     step_val = pattern;
            endcase
        end

        // A reload takes priority over a coincident tick; that tick is not counted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pattern <= LED_W'(1);
                div     <= '0;
            end else if (reload) begin
                pattern <= reload_pat;
                div     <= '0;
            end else if (wrap) begin
                if (div == DIV_W'(k)) begin
                    pattern <= step_val;
                    div     <= '0;
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end

        assign led_out[k*LED_W +: LED_W] = pattern;
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench: cycle-by-cycle model comparison plus hand-computed checkpoints.
module tb_led_pattern_engine;

    localparam int LED_W   = 4;
    localparam int NUM_CH  = 2;
    localparam int PRESC_W = 3;
    localparam int DB_W    = 2;
    localparam int PMAX    = (1 << PRESC_W) - 1;
    localparam int DB_N    = 1 << DB_W;
    localparam int PMASK   = (1 << LED_W) - 1;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic                    mode_btn;
    logic [NUM_CH*LED_W-1:0] led_out;
    logic [1:0]              mode_out;
    logic                    tick_out;

    int tests_run = 0;
    int failures  = 0;
    bit model_live = 1'b0;

    int m_presc;
    int m_mode;
    int m_pat[NUM_CH];
    int m_ticks[NUM_CH];
    int m_sync1;
    int m_sync2;
    int m_stable;
    int m_run;
    bit m_tick;
    bit m_reload_pend;
    bit m_rise_pend;

    led_pattern_engine #(
        .LED_W  (LED_W),
        .NUM_CH (NUM_CH),
        .PRESC_W(PRESC_W),
        .DB_W   (DB_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode_btn(mode_btn),
        .led_out (led_out),
        .mode_out(mode_out),
        .tick_out(tick_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic btn_v);
        rst      = rst_v;
        en       = en_v;
        mode_btn = btn_v;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (tick_out !== 1'b1 && cycles < 20);
        if (tick_out !== 1'b1) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL tick_wait: no tick_out within %0d cycles, got %b expected 1", cycles, tick_out);
        end
    endtask

    function automatic int step_model(input int p, input int mode);
        case (mode)
            0:       return ((p << 1) | (p >> (LED_W - 1))) & PMASK;
            1:       return ((p >> 1) | ((p & 1) << (LED_W - 1))) & PMASK;
            2:       return (p + 1) % (PMASK + 1);
            default: return (p + PMASK) % (PMASK + 1);
        endcase
    endfunction

    function automatic int reload_model(input int mode);
        if (mode == 2) return 0;
        if (mode == 3) return PMASK;
        return 1;
    endfunction

    task automatic model_reset();
        m_presc = 0; m_tick = 0; m_mode = 0;
        m_sync1 = 0; m_sync2 = 0; m_stable = 0; m_run = 0;
        m_reload_pend = 0; m_rise_pend = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_pat[k] = 1;
            m_ticks[k] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, all decisions taken from pre-edge values.
    task automatic model_step();
        bit wrap;
        bit rise_new;
        int sample;
        wrap = en && (m_presc == PMAX);
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_reload_pend) begin
                m_pat[k] = reload_model(m_mode);
                m_ticks[k] = 0;
            end else if (wrap) begin
                m_ticks[k]++;
                if (m_ticks[k] % (k + 1) == 0) m_pat[k] = step_model(m_pat[k], m_mode);
            end
        end
        m_reload_pend = m_rise_pend;
        if (m_rise_pend) m_mode = (m_mode + 1) % 4;
        sample = m_sync2;
        rise_new = 1'b0;
        if (sample != m_stable) begin
            m_run++;
            if (m_run == DB_N) begin
                m_stable = sample;
                m_run = 0;
                rise_new = (sample == 1);
            end
        end else begin
            m_run = 0;
        end
        m_rise_pend = rise_new;
        m_sync2 = m_sync1;
        m_sync1 = int'(mode_btn);
        m_tick = wrap;
        if (en) m_presc = wrap ? 0 : m_presc + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic [NUM_CH*LED_W-1:0] exp_led;
            exp_led = '0;
            for (int k = 0; k < NUM_CH; k++) exp_led[k*LED_W +: LED_W] = LED_W'(m_pat[k]);
            checkOutput("model_led", 32'(led_out), 32'(exp_led));
            checkOutput("model_mode", 32'(mode_out), 32'(m_mode));
            checkOutput("model_tick", 32'(tick_out), 32'(m_tick));
        end
    end

    initial begin
        int n;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        model_live = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_led", 32'(led_out), 32'h11);
        checkOutput("reset_mode", 32'(mode_out), 32'h0);
        checkOutput("reset_tick", 32'(tick_out), 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_tick(n);
        checkOutput("first_tick_latency", 32'(n), 32'd8);
        checkOutput("rotl_tick1", 32'(led_out), 32'h12);
        wait_tick(n);
        checkOutput("rotl_tick2", 32'(led_out), 32'h24);
        wait_tick(n);
        checkOutput("rotl_tick3", 32'(led_out), 32'h28);
        wait_tick(n);
        checkOutput("rotl_tick4", 32'(led_out), 32'h41);

        mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        mode_btn = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("short_press_ignored", 32'(mode_out), 32'h0);

        mode_btn = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("mode_before_latency", 32'(mode_out), 32'h0);
        @(negedge clk);
        checkOutput("mode_at_latency", 32'(mode_out), 32'h1);
        @(negedge clk);
        checkOutput("reload_rot_r", 32'(led_out), 32'h11);
        wait_tick(n);
        checkOutput("rotr_first_step", 32'(led_out), 32'h18);
        mode_btn = 1'b0;
        repeat (10) @(negedge clk);

        mode_btn = 1'b1;
        repeat (8) @(negedge clk);
        mode_btn = 1'b0;
        checkOutput("mode_cnt_up", 32'(mode_out), 32'h2);
        checkOutput("reload_cnt_up", 32'(led_out), 32'h00);
        repeat (15) wait_tick(n);
        checkOutput("cnt_up_15", 32'(led_out), 32'h7F);
        wait_tick(n);
        checkOutput("cnt_up_wrap", 32'(led_out), 32'h80);

        mode_btn = 1'b1;
        repeat (8) @(negedge clk);
        mode_btn = 1'b0;
        checkOutput("mode_cnt_dn", 32'(mode_out), 32'h3);
        checkOutput("reload_cnt_dn", 32'(led_out), 32'hFF);
        wait_tick(n);
        checkOutput("cnt_dn_1", 32'(led_out), 32'hFE);
        wait_tick(n);
        checkOutput("cnt_dn_2", 32'(led_out), 32'hED);
        repeat (13) wait_tick(n);
        checkOutput("cnt_dn_15", 32'(led_out), 32'h80);
        wait_tick(n);
        checkOutput("cnt_dn_wrap", 32'(led_out), 32'h7F);

        // Press lands so that the reload edge is also a prescaler wrap edge.
        wait_tick(n);
        mode_btn = 1'b1;
        repeat (8) @(negedge clk);
        mode_btn = 1'b0;
        checkOutput("coincide_mode", 32'(mode_out), 32'h0);
        checkOutput("coincide_tick", 32'(tick_out), 32'h1);
        checkOutput("coincide_reload", 32'(led_out), 32'h11);
        wait_tick(n);
        checkOutput("after_coincide", 32'(led_out), 32'h12);

        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("frozen_led", 32'(led_out), 32'h12);
        checkOutput("frozen_tick", 32'(tick_out), 32'h0);
        en = 1'b1;
        wait_tick(n);
        checkOutput("resume_latency", 32'(n), 32'd5);
        checkOutput("resume_step", 32'(led_out), 32'h24);

        repeat (8) @(negedge clk);
        mode_btn = 1'b1;
        repeat (8) @(negedge clk);
        mode_btn = 1'b0;
        checkOutput("pre_rst_mode", 32'(mode_out), 32'h1);
        wait_tick(n);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_led", 32'(led_out), 32'h11);
        checkOutput("async_rst_mode", 32'(mode_out), 32'h0);
        checkOutput("async_rst_tick", 32'(tick_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n);
        checkOutput("post_rst_latency", 32'(n), 32'd8);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
